operand_sel_pipe: RTL

OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

---
 rtl/operand_sel_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/operand_sel_pipe.sv
// Operand select pipeline: picks one of NUM_IN packed operands per accepted beat
// and buffers the result (plus an out-of-range flag) in a 2-entry in-order FIFO.
// A sticky flag records any out-of-range select until it is explicitly cleared.
module operand_sel_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    flush_i,
    input  logic                    clr_err_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_err_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    err_sticky_o,
    output logic [1:0]              count_o
);

    // FIFO storage and control state
    logic [WIDTH-1:0] r_data [2];
    logic             r_err  [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic [1:0]       w_count_d;
    logic             r_sticky;

    logic             w_sel_ok;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_push_data;
    logic             w_push_err;
    logic             w_push;
    logic             w_pop;

    // A select is legal only when it names one of the NUM_IN inputs; for a
    // non-power-of-two NUM_IN the top codes are out of range.
    assign w_sel_ok = (32'(sel_i) < NUM_IN);

    // Operand mux: only in-range indices are decoded, so an out-of-range select
    // never indexes past the packed input vector and yields zero.
    always_comb begin
        w_sel_data = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                w_sel_data = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_push_data = w_sel_ok ? w_sel_data : '0;
    assign w_push_err  = ~w_sel_ok;

    // Handshakes; flush suppresses both so nothing is stored or consumed.
    assign in_ready_o  = (r_count != 2'd2);
    assign out_valid_o = (r_count != 2'd0);
    assign w_push      = in_valid_i & in_ready_o & ~flush_i;
    assign w_pop       = out_valid_o & out_ready_i & ~flush_i;

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 2'd1;
            2'b01:   w_count_d = r_count - 2'd1;
            default: w_count_d = r_count;
        endcase
    end

    // Entry storage: write the selected operand at the write pointer on a push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_err[0]  <= 1'b0;
            r_err[1]  <= 1'b0;
        end else if (w_push) begin
            r_data[r_wptr] <= w_push_data;
            r_err[r_wptr]  <= w_push_err;
        end
    end

    // Pointers and count; 1-bit pointers wrap modulo 2 naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else if (flush_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_d;
        end
    end

    // Sticky error: a push of an out-of-range beat beats a same-cycle clear;
    // flush deliberately leaves it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sticky <= 1'b0;
        end else if (w_push && w_push_err) begin
            r_sticky <= 1'b1;
        end else if (clr_err_i) begin
            r_sticky <= 1'b0;
        end
    end

    // Head presentation is gated by valid so an empty FIFO shows zeros rather
    // than stale entries left behind by a flush.
    assign out_data_o   = out_valid_o ? r_data[r_rptr] : '0;
    assign out_err_o    = out_valid_o ? r_err[r_rptr] : 1'b0;
    assign err_sticky_o = r_sticky;
    assign count_o      = r_count;

endmodule
